// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arithmetic/compare operations, and
// shifts performed one bit per clock through an accumulator.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   request valid; captured when in_ready is high
//   in_ready   high only while idle
//   Operation  4-bit operation code
//   A, B       operands; B[SW-1:0] is the shift amount
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     operation result (registered)
//   zero       result == 0 (registered alongside result)
module iter_alu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    localparam int unsigned SW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_LT  = 4'b1000;
    localparam logic [3:0] OP_EQ  = 4'b1001;
    localparam logic [3:0] OP_NE  = 4'b1010;
    localparam logic [3:0] OP_GE  = 4'b1011;
    localparam logic [3:0] OP_PB  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [SW-1:0]         cnt;
    logic [3:0]            op_q;

    logic [SW-1:0]         shamt;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] alu_c;
    logic [DATA_WIDTH-1:0] step_c;

    assign shamt    = B[SW-1:0];
    assign is_shift = (Operation == OP_SRL) || (Operation == OP_SRA) ||
                      (Operation == OP_SLL);

    // Single-cycle result from the live inputs at the capture edge.
    // Shift codes only reach this path with a zero shift amount, so they pass A.
    always_comb begin
        alu_c = '0;
        unique case (Operation)
            OP_AND: alu_c = A & B;
            OP_OR:  alu_c = A | B;
            OP_ADD: alu_c = A + B;
            OP_SUB: alu_c = A - B;
            OP_XOR: alu_c = A ^ B;
            OP_SRL, OP_SRA, OP_SLL: alu_c = A;
            OP_LT:  alu_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) <  $signed(B))};
            OP_EQ:  alu_c = {{(DATA_WIDTH-1){1'b0}}, (A == B)};
            OP_NE:  alu_c = {{(DATA_WIDTH-1){1'b0}}, (A != B)};
            OP_GE:  alu_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) >= $signed(B))};
            OP_PB:  alu_c = B;
            default: alu_c = '0;
        endcase
    end

    // One-bit shift step of the accumulator for the latched operation.
    always_comb begin
        step_c = acc;
        unique case (op_q)
            OP_SLL:  step_c = {acc[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  step_c = {1'b0, acc[DATA_WIDTH-1:1]};
            OP_SRA:  step_c = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
            default: step_c = acc;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= Operation;
                        in_ready <= 1'b0;
                        if (is_shift && (shamt != '0)) begin
                            acc   <= A;
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            result    <= alu_c;
                            zero      <= (alu_c == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= step_c;
                    cnt <= cnt - SW'(1);
                    // Last step: publish the shifted value directly.
                    if (cnt == SW'(1)) begin
                        result    <= step_c;
                        zero      <= (step_c == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; shift amount width SW = log2(DATA_WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 Operation  input  4  ALU operation code from ALUController.
REQ-007 A  input  DATA_WIDTH  operand A (rs1 / PC).
REQ-008 B  input  DATA_WIDTH  operand B (rs2 / immediate); B[SW-1:0] = shift amount.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  DATA_WIDTH  operation result.
REQ-012 zero  output  1  result == 0.

Function
REQ-013 Operation decode SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 XOR; 0101 SRL; 0110 SRA; 0111 SLL; 1000 signed A<B (SLT/BLT); 1001 A==B; 1010 A!=B; 1011 signed A>=B; 1111 pass B (JAL/LUI); 1100/1101/1110 result 0.
REQ-014 Compare/branch codes (1000-1011) SHALL return 1 or 0 in result[0], upper bits 0.
REQ-015 ADD/SUB SHALL be modulo 2^DATA_WIDTH, no overflow/carry output.
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-017 Request captured at edge E0 when in_valid && in_ready; Operation, A, B latched; later input changes ignored until return to IDLE.
REQ-018 Non-shift codes, and shifts with shamt 0: result computed from latched inputs at E0, state -> DONE at E0 (out_valid high the following cycle).
REQ-019 Shifts with shamt>0: E0 loads accumulator = A, counter = shamt, state -> SHIFT; each SHIFT edge shifts accumulator by exactly 1 bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrements counter; edge where counter goes 1->0 moves to DONE; out_valid high after edge E0+shamt.
REQ-020 Shift amount SHALL use B[SW-1:0] only; upper B bits ignored.
REQ-021 DONE: out_valid=1, result/zero held stable; edge with out_ready=1 -> IDLE, out_valid=0.
REQ-022 in_ready SHALL be 0 in SHIFT and DONE; no new request accepted same edge as result handshake (one idle cycle between operations).
REQ-023 in_valid in SHIFT/DONE SHALL be ignored, not queued.
REQ-024 zero SHALL equal (result == 0) in every cycle, including compare codes.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 reset asserted SHALL immediately (no clock) force state IDLE, result 0, zero 1, out_valid 0, in_ready 1, accumulator/counter 0.
REQ-027 Reset mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse after deassertion.
REQ-028 First capture possible at first rising edge after reset deasserts.

Verification
REQ-029 ADD: Operation=0010, A=5, B=7, in_valid 1 cycle -> out_valid next cycle, result 12, zero 0.
REQ-030 SRA: Operation=0110, A=0x80000000, B=4 -> in_ready 0 for shift cycles, out_valid after 4 edges, result 0xF8000000; SRL same inputs -> 0x08000000.
REQ-031 Compares: 1011 A=0xFFFFFFFF, B=1 -> result 0, zero 1; 1001 A=B=3 -> result 1; 1000 A=0xFFFFFFFF, B=0 -> result 1.
REQ-032 Backpressure: XOR A=0xF0F0F0F0, B=0xFFFFFFFF, out_ready 0 for 3 cycles -> result 0x0F0F0F0F stable, in_ready 0, in_valid ignored; out_ready 1 -> IDLE next edge.
REQ-033 Reset mid-op: SLL A=1, B=31, assert reset after 10 shift edges -> out_valid 0, in_ready 1, result 0 at once; no stale result later.
REQ-034 Edge codes: SLL B=0x20 (shamt 0), A=0x1234 -> result 0x1234 next cycle; Operation=1101 -> result 0, zero 1; 1111 B=0xABCD0000 -> result 0xABCD0000.
